fft_fifo_frame_ctrl: RTL and testbench
======================================

Name: fft_fifo_frame_ctrl

Overview:
- Read-side sequencer for the single-clock (c_FIFO_TYPE="SYN", c_OUTPUT_REG=0) FFT input FIFO.
- Waits until the FIFO holds at least one full frame, then drains exactly FRAME_LEN samples into the FFT core's AXI-Stream slave and marks the final beat with tlast.
- Absorbs the FIFO's 1-cycle read latency with a small skid buffer, so backpressure from the FFT never drops or duplicates a sample.
- Keeps a frame counter and an underflow error flag.

Parameters:
- DATA_WIDTH, 32, sample width; matches FIFO c_RD_DATA_WIDTH.
- LEVEL_WIDTH, 11, width of rd_water_level; equals c_RD_DEPTH_WIDTH+1.
- FRAME_LEN, 1024, samples per FFT frame. Legal range 2 to 2^(LEVEL_WIDTH-1).
- SKID_DEPTH, 4, output skid buffer entries. Minimum 2; power of two.

Ports:
- clk  in  1  single clock; same clock as the FIFO wr_clk/rd_clk.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  frame-start enable, level-sensitive.
- err_clr  in  1  clears err_underflow; single-cycle pulse.
- fifo_rd_en  out  1  drives FIFO rd_en.
- fifo_rd_data  in  DATA_WIDTH  FIFO rd_data.
- fifo_rd_empty  in  1  FIFO rd_empty.
- fifo_rd_water_level  in  LEVEL_WIDTH  FIFO rd_water_level.
- m_axis_tdata  out  DATA_WIDTH  sample to the FFT.
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- m_axis_tlast  out  1  high on the last beat of a frame.
- frame_cnt  out  16  completed frames; wraps 0xFFFF->0.
- busy  out  1  high when the state is not IDLE/WAIT_LVL.
- err_underflow  out  1  sticky underflow flag.

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE, fifo_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_cnt=0, busy=0, err_underflow=0, skid buffer empty, counters=0.
- FIFO read timing:
  - FIFO rd_en doubles as its read clock enable.
  - Data is valid on fifo_rd_data one cycle after fifo_rd_en=1 and stays held while rd_en=0.
  - The block captures fifo_rd_data into the skid buffer on the cycle after each issued read.
- Credit rule: fifo_rd_en may be 1 only when (inflight + skid_count) < SKID_DEPTH and fifo_rd_empty=0. inflight is 0 or 1.
- State IDLE: go to WAIT_LVL when en=1.
- State WAIT_LVL:
  - If en=0, return to IDLE.
  - If fifo_rd_water_level >= FRAME_LEN, go to STREAM and clear issue_cnt and beat_cnt.
- State STREAM:
  - Assert fifo_rd_en whenever the credit rule allows; issue_cnt++ per read.
  - When issue_cnt reaches FRAME_LEN, stop reading and go to DRAIN.
- State DRAIN:
  - Wait for the beat with tlast to complete (tvalid & tready).
  - On that beat: frame_cnt++, then go to WAIT_LVL if en=1, else IDLE.
- Enable handling: dropping en mid-frame does not abort; the frame always completes.
- Output side:
  - m_axis_tvalid = skid_count != 0. tdata is the skid head.
  - beat_cnt++ on each handshake. m_axis_tlast = tvalid & (beat_cnt == FRAME_LEN-1).
  - tdata/tlast stay stable while tvalid & !tready (AXI rule).
- Throughput: with tready held at 1, one beat per cycle after a 2-cycle startup (read issue, then capture).
- Underflow:
  - Condition: in STREAM with reads outstanding, credit available, but fifo_rd_empty=1. This cannot happen given the level check, so it indicates an upstream fault.
  - Response: set err_underflow, and the read stalls until data arrives (no abort).
  - err_clr clears the flag. If err_clr and a new set condition occur in the same cycle, set wins.
- Simultaneous events:
  - Skid push and pop in the same cycle leave skid_count unchanged.
  - A tlast handshake and the FIFO reaching the next-frame level in the same cycle: transition to WAIT_LVL, which re-evaluates the level the following cycle.
- Frame counter: 16-bit, wraps modulo 2^16.

Decomposition:
- Package fft_fifo_ctrl_pkg holds:
  - state enum {IDLE, WAIT_LVL, STREAM, DRAIN};
  - localparam CNT_W = $clog2(FRAME_LEN+1);
  - the SKID_DEPTH minimum check.
- Sub-module fft_skid_buf: a SKID_DEPTH x DATA_WIDTH register FIFO with push/pop, head data and a count output. No RAM primitive is used.
- The top level holds the FSM, issue/beat counters, credit logic and error flag.

Test Plan:
- Normal frame. FRAME_LEN=8, FIFO preloaded with 0..9, en=1, tready=1 → fifo_rd_en high for exactly 8 cycles; beats 0..7 on consecutive cycles; tlast on data 7 only; frame_cnt=1; 2 words remain; state back in WAIT_LVL.
- Level gating. Level=7 with FRAME_LEN=8 → no fifo_rd_en, tvalid=0. Write 1 more word → STREAM entered the cycle after level reads 8.
- Backpressure. tready toggles 1,0,0,1 randomly over a frame of 0..7 → output sequence is exactly 0..7 with no duplicates or drops; inflight+skid_count never exceeds 4; tdata is stable during stalls.
- Enable drop mid-frame. en=0 after beat 3 → remaining beats 4..7 are delivered, tlast on 7, state goes to IDLE, and no further reads occur although the FIFO holds 8 more words.
- Underflow injection. Force fifo_rd_empty=1 for 3 cycles mid-STREAM → err_underflow=1 and held; reads resume and the frame completes; an err_clr pulse returns it to 0.
- Reset mid-frame. Deassert rst_n during beat 4 → all outputs reach their reset values immediately; after release with en=1, the block waits for level >= FRAME_LEN again; frame_cnt=0.

Source files
------------

// File: rtl/fft_fifo_ctrl_pkg.sv
// rtl/fft_fifo_ctrl_pkg.sv - shared types and elaboration helpers for the FFT FIFO frame controller
package fft_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LVL = 2'd1,
        STREAM   = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    localparam int SKID_DEPTH_MIN = 2;

    // Width of the issue/beat counters: they must be able to hold FRAME_LEN itself.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Skid buffer pointers wrap naturally, so the depth must be a power of two.
    function automatic bit skid_depth_ok(input int depth);
        return (depth >= SKID_DEPTH_MIN) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// rtl/fft_skid_buf.sv - register-based skid FIFO between the FIFO read port and the AXI-S output
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i            write push_data_i this cycle (ignored when full and not popping)
//   pop_i             drop the head entry this cycle (ignored when empty)
//   head_data_o       oldest entry; zero after reset
//   count_o           number of valid entries, 0..DEPTH
module fft_skid_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full buffer is still accepted when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fft_fifo_frame_ctrl.sv
// rtl/fft_fifo_frame_ctrl.sv - read-side frame sequencer feeding an FFT core from a synchronous FIFO
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (released synchronously inside)
//   en                         level-sensitive frame-start enable
//   err_clr                    pulse to clear err_underflow
//   fifo_rd_en                 FIFO read enable (also its read clock enable)
//   fifo_rd_data               FIFO read data, valid the cycle after a read
//   fifo_rd_empty              FIFO empty flag
//   fifo_rd_water_level        FIFO fill level
//   m_axis_tdata/tvalid/tready/tlast   AXI-Stream master toward the FFT
//   frame_cnt                  completed frames, wraps at 16 bits
//   busy                       high while streaming or draining a frame
//   err_underflow              sticky flag: FIFO ran dry mid-frame
module fft_fifo_frame_ctrl
    import fft_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 11,
    parameter int FRAME_LEN   = 1024,
    parameter int SKID_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   err_clr,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [15:0]            frame_cnt,
    output logic                   busy,
    output logic                   err_underflow
);

    localparam int CNT_W  = cnt_width(FRAME_LEN);
    localparam int SCNT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [CNT_W-1:0]       FRAME_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_FRAME = LEVEL_WIDTH'(FRAME_LEN);
    localparam logic [SCNT_W:0]        CREDIT_MAX  = (SCNT_W + 1)'(SKID_DEPTH);

    if (!skid_depth_ok(SKID_DEPTH)) begin : g_bad_skid_depth
        $error("SKID_DEPTH must be a power of two and at least 2");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > (1 << (LEVEL_WIDTH - 1))) begin : g_bad_frame_len
        $error("FRAME_LEN out of range for LEVEL_WIDTH");
    end

    // Reset asserts asynchronously but releases two clocks later, aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               inflight_q;
    logic [15:0]        frame_cnt_q;
    logic               err_q;

    logic [SCNT_W-1:0]  skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic               credit_ok;
    logic               beat_fire;
    logic               last_fire;
    logic               uf_set;
    logic               rd_en;

    // Every slot is either occupied or reserved by the read still in flight,
    // so a captured word always has room and backpressure cannot drop data.
    assign credit_ok = ({1'b0, skid_count} + (SCNT_W + 1)'(inflight_q)) < CREDIT_MAX;

    assign m_axis_tvalid = (skid_count != '0);
    assign m_axis_tdata  = skid_head;
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == FRAME_LAST);
    assign beat_fire     = m_axis_tvalid && m_axis_tready;
    assign last_fire     = beat_fire && m_axis_tlast;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        rd_en       = 1'b0;
        uf_set      = 1'b0;

        if (beat_fire) begin
            beat_cnt_d = last_fire ? '0 : beat_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = WAIT_LVL;
                end
            end
            WAIT_LVL: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (fifo_rd_water_level >= LEVEL_FRAME) begin
                    state_d     = STREAM;
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                end
            end
            STREAM: begin
                if (credit_ok) begin
                    if (fifo_rd_empty) begin
                        // Level said a full frame was present; running dry is an upstream fault.
                        uf_set = 1'b1;
                    end else begin
                        rd_en       = 1'b1;
                        issue_cnt_d = issue_cnt_q + CNT_W'(1);
                        if (issue_cnt_q == FRAME_LAST) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (last_fire) begin
                    state_d = en ? WAIT_LVL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= rd_en;
            if (last_fire) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (uf_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // The word read last cycle is on fifo_rd_data now; capture it.
    fft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (rst_int_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (beat_fire),
        .head_data_o (skid_head),
        .count_o     (skid_count)
    );

    assign fifo_rd_en    = rd_en;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = (state_q == STREAM) || (state_q == DRAIN);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fft_fifo_frame_ctrl.sv
// tb/tb_fft_fifo_frame_ctrl.sv - randomized self-checking bench for fft_fifo_frame_ctrl
module tb_fft_fifo_frame_ctrl;

    localparam int DW = 32;
    localparam int LW = 11;
    localparam int FL = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          err_clr = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_water_level;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [15:0]   frame_cnt;
    logic          busy;
    logic          err_underflow;

    always #5 clk = ~clk;

    fft_fifo_frame_ctrl #(
        .DATA_WIDTH  (DW),
        .LEVEL_WIDTH (LW),
        .FRAME_LEN   (FL),
        .SKID_DEPTH  (SD)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .err_clr             (err_clr),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .frame_cnt           (frame_cnt),
        .busy                (busy),
        .err_underflow       (err_underflow)
    );

    // Synchronous FIFO environment: rd_data registered one cycle after rd_en, held otherwise.
    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    bit            force_empty = 1'b0;

    assign fifo_rd_water_level = LW'(wr_ptr - rd_ptr);
    assign fifo_rd_empty       = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rd_data <= mem[rd_ptr & 255];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Reference model: every written word leaves in write order, every FL-th beat carries tlast.
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            rd_cycles = 0;
    int            out_cnt = 0;
    int            model_beat = 0;
    int            model_frames = 0;
    int            first_rd = -1;
    int            first_hs = -1;
    int            last_hs = -1;
    int            rd_base;
    bit            rdy_rand = 1'b0;
    bit            stall_prev = 1'b0;
    bit            prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        m_axis_tready = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_ptr & 255] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 300 && frame_cnt != 16'(target); i++) begin
            tick();
        end
        check("frame_cnt", frame_cnt, target);
        check("frame_model", frame_cnt, model_frames);
    endtask

    // Monitor: samples between edges, judging the handshake that the next edge will commit.
    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst_n) begin
            check("outstanding_le_depth", (out_cnt <= SD), 1);
            if (fifo_rd_en) begin
                check("rd_not_empty", fifo_rd_empty, 0);
                rd_cycles++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (stall_prev) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_last", m_axis_tlast, prev_last);
            end
            if (!m_axis_tvalid) begin
                check("tlast_idle", m_axis_tlast, 0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_d = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, exp_d);
                end
                check("beat_last", m_axis_tlast, (model_beat == FL - 1));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                model_beat = (model_beat + 1) % FL;
                if (model_beat == 0) model_frames = (model_frames + 1) % 65536;
                out_cnt--;
            end
            if (fifo_rd_en) out_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            out_cnt      = 0;
            model_beat   = 0;
            model_frames = 0;
            stall_prev   = 1'b0;
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_underflow, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Normal frame: 0..9 preloaded, tready held high.
        for (int i = 0; i < 10; i++) fifo_write(DW'(i));
        first_rd = -1; first_hs = -1; rd_base = rd_cycles;
        en = 1'b1;
        wait_frame(1);
        repeat (4) tick();
        check("t1_rd_cycles", rd_cycles - rd_base, FL);
        check("t1_burst", last_hs - first_hs, FL - 1);
        check("t1_latency", first_hs - first_rd, 2);
        check("t1_level", fifo_rd_water_level, 2);
        check("t1_busy", busy, 0);
        check("t1_tvalid", m_axis_tvalid, 0);

        // Level gating: 7 words must not start a frame, the 8th must.
        for (int i = 0; i < 5; i++) fifo_write($urandom);
        rd_base = rd_cycles;
        repeat (10) tick();
        check("t2_no_rd", rd_cycles - rd_base, 0);
        check("t2_tvalid", m_axis_tvalid, 0);
        check("t2_level7", fifo_rd_water_level, 7);
        fifo_write($urandom);
        check("t2_busy_pre", busy, 0);
        tick();
        check("t2_busy", busy, 1);
        check("t2_rd_en", fifo_rd_en, 1);
        wait_frame(2);

        // Backpressure: random tready over a full frame.
        rdy_rand = 1'b1;
        for (int i = 0; i < FL; i++) fifo_write($urandom);
        wait_frame(3);
        rdy_rand = 1'b0;
        tick();

        // Enable dropped after beat 3: frame completes, nothing further is read.
        for (int i = 0; i < 2 * FL; i++) fifo_write($urandom);
        for (int i = 0; i < 100 && model_beat < 4; i++) tick();
        check("t4_reach_beat4", (model_beat >= 4), 1);
        en = 1'b0;
        wait_frame(4);
        rd_base = rd_cycles;
        repeat (20) tick();
        check("t4_no_rd", rd_cycles - rd_base, 0);
        check("t4_level", fifo_rd_water_level, FL);
        check("t4_busy", busy, 0);

        // Underflow injection, including err_clr colliding with a set.
        en = 1'b1;
        rd_base = rd_cycles;
        for (int i = 0; i < 50 && (rd_cycles - rd_base) < 3; i++) tick();
        force_empty = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        force_empty = 1'b0;
        check("t5_err_set", err_underflow, 1);
        wait_frame(5);
        check("t5_err_held", err_underflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_clr", err_underflow, 0);

        // Reset during beat 4.
        for (int i = 0; i < 12; i++) fifo_write($urandom);
        for (int i = 0; i < 100 && !(model_beat >= 4 && m_axis_tvalid); i++) tick();
        check("t6_reach_beat4", (model_beat >= 4), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rd_en", fifo_rd_en, 0);
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_tlast", m_axis_tlast, 0);
        check("t6_tdata", m_axis_tdata, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err_underflow, 0);
        exp_q.delete();
        for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(mem[p & 255]);
        repeat (2) tick();
        rst_n = 1'b1;
        while ((wr_ptr - rd_ptr) < FL - 1) fifo_write($urandom);
        rd_base = rd_cycles;
        repeat (10) tick();
        check("t6_wait_lvl", rd_cycles - rd_base, 0);
        check("t6_busy_wait", busy, 0);
        fifo_write($urandom);
        wait_frame(1);

        repeat (4) tick();
        check("end_scoreboard", exp_q.size(), wr_ptr - rd_ptr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
